// File: rtl/serial_pkg.sv
// Shared definitions for the serial deserializer family: comma constants,
// alignment state encoding and a width helper.
package serial_pkg;

   localparam logic [7:0] K28_5 = 8'hBC;

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } sync_state_t;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/serial_parallel_sync_comma_detector.sv
// Combinational comma matcher for one candidate word; shared with the
// multi-lane aligners.
module comma_detector #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] COMMA = '0
) (
   input  logic [WIDTH-1:0] candidate,
   output logic             match
);

   assign match = (candidate == COMMA);

endmodule

// File: rtl/serial_parallel_sync.sv
// Serial-to-parallel deserializer that aligns word boundaries to a comma
// pattern, strobes each completed word and drops lock after a comma drought.
module serial_parallel_sync
   import serial_pkg::*;
#(
   parameter int               WIDTH         = 8,
   parameter logic [WIDTH-1:0] COMMA         = WIDTH'(K28_5),
   parameter bit               MSB_FIRST     = 1'b1,
   parameter int               TIMEOUT_WORDS = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             DATA_IN,
   input  logic             BIT_VALID,
   output logic [WIDTH-1:0] DATA_OUT,
   output logic             DATA_VALID,
   output logic             IS_COMMA,
   output logic             LOCKED,
   output logic             SYNC_LOSS
);

   localparam int BIT_W = clog2(WIDTH);
   localparam int WC_W  = (TIMEOUT_WORDS > 0) ? clog2(TIMEOUT_WORDS + 1) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
   localparam logic [WC_W-1:0]  WC_LAST  = (TIMEOUT_WORDS > 0) ? WC_W'(TIMEOUT_WORDS - 1) : '0;

   sync_state_t      state, state_nxt;
   logic [WIDTH-1:0] sr, sr_nxt, w_next, data_out_nxt;
   logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
   logic [WC_W-1:0]  word_cnt, word_cnt_nxt;
   logic             data_valid_nxt, is_comma_nxt, locked_nxt, sync_loss_nxt;
   logic             comma_match;

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_next = {sr[WIDTH-2:0], DATA_IN};
      end else begin : g_lsb_first
         assign w_next = {DATA_IN, sr[WIDTH-1:1]};
      end
   endgenerate

   comma_detector #(
      .WIDTH (WIDTH),
      .COMMA (COMMA)
   ) u_comma_detector (
      .candidate (w_next),
      .match     (comma_match)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= ST_SEARCH;
         sr         <= '0;
         bit_cnt    <= '0;
         word_cnt   <= '0;
         DATA_OUT   <= '0;
         DATA_VALID <= 1'b0;
         IS_COMMA   <= 1'b0;
         LOCKED     <= 1'b0;
         SYNC_LOSS  <= 1'b0;
      end else begin
         state      <= state_nxt;
         sr         <= sr_nxt;
         bit_cnt    <= bit_cnt_nxt;
         word_cnt   <= word_cnt_nxt;
         DATA_OUT   <= data_out_nxt;
         DATA_VALID <= data_valid_nxt;
         IS_COMMA   <= is_comma_nxt;
         LOCKED     <= locked_nxt;
         SYNC_LOSS  <= sync_loss_nxt;
      end
   end

   // Only aligned words are compared while locked, so a stray comma mid-word never realigns.
   always_comb begin
      state_nxt      = state;
      sr_nxt         = sr;
      bit_cnt_nxt    = bit_cnt;
      word_cnt_nxt   = word_cnt;
      data_out_nxt   = DATA_OUT;
      data_valid_nxt = 1'b0;
      is_comma_nxt   = 1'b0;
      locked_nxt     = LOCKED;
      sync_loss_nxt  = 1'b0;
      if (BIT_VALID) begin
         sr_nxt = w_next;
         case (state)
            ST_SEARCH: begin
               if (comma_match) begin
                  data_out_nxt   = COMMA;
                  data_valid_nxt = 1'b1;
                  is_comma_nxt   = 1'b1;
                  locked_nxt     = 1'b1;
                  bit_cnt_nxt    = '0;
                  word_cnt_nxt   = '0;
                  state_nxt      = ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               if (bit_cnt == BIT_LAST) begin
                  data_out_nxt   = w_next;
                  data_valid_nxt = 1'b1;
                  is_comma_nxt   = comma_match;
                  bit_cnt_nxt    = '0;
                  if (comma_match) begin
                     word_cnt_nxt = '0;
                  end else if (TIMEOUT_WORDS > 0 && word_cnt == WC_LAST) begin
                     sync_loss_nxt = 1'b1;
                     locked_nxt    = 1'b0;
                     word_cnt_nxt  = '0;
                     state_nxt     = ST_SEARCH;
                  end else if (word_cnt != '1) begin
                     word_cnt_nxt = word_cnt + 1'b1;
                  end
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end
            default: state_nxt = ST_SEARCH;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_parallel_sync.sv
// Scoreboard bench: an 8-bit MSB-first lane with a short timeout and a 10-bit
// LSB-first lane, both checked against a bit-history reference model.
module tb_serial_parallel_sync;

   typedef struct {
      logic [9:0] data;
      logic       comma;
      logic       sl;
      int         cyc;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       DATA_IN0 = 1'b0, BIT_VALID0 = 1'b0;
   logic       DATA_IN1 = 1'b0, BIT_VALID1 = 1'b0;
   logic [7:0] DATA_OUT0;
   logic [9:0] DATA_OUT1;
   logic       DATA_VALID0, IS_COMMA0, LOCKED0, SYNC_LOSS0;
   logic       DATA_VALID1, IS_COMMA1, LOCKED1, SYNC_LOSS1;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   bit   mon_en = 0;
   exp_t q0[$];
   exp_t q1[$];

   int cfg_w     [2] = '{8, 10};
   int cfg_comma [2] = '{'hBC, 'h17C};
   bit cfg_msb   [2] = '{1'b1, 1'b0};
   int cfg_to    [2] = '{4, 16};

   int m_hist   [2] = '{0, 0};
   bit m_locked [2] = '{1'b0, 1'b0};
   int m_bits   [2] = '{0, 0};
   int m_nc     [2] = '{0, 0};
   bit lk_exp   [2] = '{1'b0, 1'b0};

   serial_parallel_sync #(
      .WIDTH(8), .COMMA(8'hBC), .MSB_FIRST(1'b1), .TIMEOUT_WORDS(4)
   ) dut0 (
      .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN0), .BIT_VALID(BIT_VALID0),
      .DATA_OUT(DATA_OUT0), .DATA_VALID(DATA_VALID0), .IS_COMMA(IS_COMMA0),
      .LOCKED(LOCKED0), .SYNC_LOSS(SYNC_LOSS0)
   );

   serial_parallel_sync #(
      .WIDTH(10), .COMMA(10'h17C), .MSB_FIRST(1'b0), .TIMEOUT_WORDS(16)
   ) dut1 (
      .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN1), .BIT_VALID(BIT_VALID1),
      .DATA_OUT(DATA_OUT1), .DATA_VALID(DATA_VALID1), .IS_COMMA(IS_COMMA1),
      .LOCKED(LOCKED1), .SYNC_LOSS(SYNC_LOSS1)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      cyc       <= cyc + 1;
      lk_exp[0] <= m_locked[0];
      lk_exp[1] <= m_locked[1];
   end

   task automatic check(input string name, input int lane, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL lane%0d %s: got %h, required %h (cycle %0d)", lane, name, act, req, cyc);
      end
   endtask

   function automatic void push_exp(input int lane, input int word, input bit c, input bit s);
      exp_t e;
      e.data  = word[9:0];
      e.comma = c;
      e.sl    = s;
      e.cyc   = cyc + 1;
      if (lane == 0) q0.push_back(e);
      else           q1.push_back(e);
   endfunction

   // Reference: keep the last WIDTH bits as a number and read the word out in arrival order.
   function automatic void model_step(input int lane, input bit b);
      int w, word;
      w = cfg_w[lane];
      m_hist[lane] = ((m_hist[lane] << 1) | int'(b)) & ((1 << w) - 1);
      if (cfg_msb[lane]) begin
         word = m_hist[lane];
      end else begin
         word = 0;
         for (int i = 0; i < w; i++)
            if (((m_hist[lane] >> i) & 1) == 1) word = word | (1 << (w - 1 - i));
      end
      if (!m_locked[lane]) begin
         if (word == cfg_comma[lane]) begin
            push_exp(lane, word, 1'b1, 1'b0);
            m_locked[lane] = 1'b1;
            m_bits[lane]   = 0;
            m_nc[lane]     = 0;
         end
      end else begin
         m_bits[lane]++;
         if (m_bits[lane] == w) begin
            m_bits[lane] = 0;
            if (word == cfg_comma[lane]) begin
               m_nc[lane] = 0;
               push_exp(lane, word, 1'b1, 1'b0);
            end else begin
               m_nc[lane]++;
               if (cfg_to[lane] > 0 && m_nc[lane] == cfg_to[lane]) begin
                  push_exp(lane, word, 1'b0, 1'b1);
                  m_locked[lane] = 1'b0;
                  m_nc[lane]     = 0;
               end else begin
                  push_exp(lane, word, 1'b0, 1'b0);
               end
            end
         end
      end
   endfunction

   task automatic check_output(input int lane, input logic dv, input logic [9:0] dout,
                               input logic ic, input logic lk, input logic sl);
      exp_t e;
      bit   have;
      have = 1'b0;
      if (lane == 0 && q0.size() > 0) begin e = q0[0]; have = 1'b1; end
      if (lane == 1 && q1.size() > 0) begin e = q1[0]; have = 1'b1; end
      if (have && e.cyc < cyc) begin
         check("missed_pulse", lane, 32'(dv), 32'd1);
         if (lane == 0) void'(q0.pop_front());
         else           void'(q1.pop_front());
         have = 1'b0;
      end
      if (dv) begin
         if (!have || e.cyc != cyc) begin
            check("unexpected_pulse", lane, 32'(dv), 32'd0);
         end else begin
            if (lane == 0) void'(q0.pop_front());
            else           void'(q1.pop_front());
            check("data_out", lane, 32'(dout), 32'(e.data));
            check("is_comma", lane, 32'(ic), 32'(e.comma));
            check("sync_loss", lane, 32'(sl), 32'(e.sl));
         end
      end else if (sl || ic) begin
         check("stray_flag", lane, {30'd0, sl, ic}, 32'd0);
      end
      check("locked", lane, 32'(lk), 32'(lk_exp[lane]));
   endtask

   always @(negedge CLK) begin
      if (mon_en) begin
         check_output(0, DATA_VALID0, {2'b00, DATA_OUT0}, IS_COMMA0, LOCKED0, SYNC_LOSS0);
         check_output(1, DATA_VALID1, DATA_OUT1, IS_COMMA1, LOCKED1, SYNC_LOSS1);
      end
   end

   task automatic apply_stimulus(input int lane, input bit b, input bit v);
      @(negedge CLK);
      #1;
      if (lane == 0) begin
         DATA_IN0 = b; BIT_VALID0 = v; BIT_VALID1 = 1'b0;
      end else begin
         DATA_IN1 = b; BIT_VALID1 = v; BIT_VALID0 = 1'b0;
      end
      if (v) model_step(lane, b);
   endtask

   task automatic send_word(input int lane, input logic [9:0] w);
      logic [9:0] wv;
      wv = w;
      for (int i = 0; i < cfg_w[lane]; i++)
         apply_stimulus(lane, cfg_msb[lane] ? wv[cfg_w[lane] - 1 - i] : wv[i], 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(0, 1'b0, 1'b0);
   endtask

   // Reset is applied with a valid bit present to show it overrides shifting.
   task automatic do_reset();
      @(negedge CLK);
      #1;
      RESET      = 1'b1;
      DATA_IN0   = 1'($urandom_range(0, 1));
      BIT_VALID0 = 1'b1;
      BIT_VALID1 = 1'b0;
      for (int l = 0; l < 2; l++) begin
         m_hist[l] = 0; m_locked[l] = 1'b0; m_bits[l] = 0; m_nc[l] = 0;
      end
      q0.delete();
      q1.delete();
      @(negedge CLK);
      check("rst_data_out", 0, 32'(DATA_OUT0), 32'd0);
      check("rst_data_valid", 0, 32'(DATA_VALID0), 32'd0);
      check("rst_is_comma", 0, 32'(IS_COMMA0), 32'd0);
      check("rst_locked", 0, 32'(LOCKED0), 32'd0);
      check("rst_sync_loss", 0, 32'(SYNC_LOSS0), 32'd0);
      check("rst_data_out", 1, 32'(DATA_OUT1), 32'd0);
      check("rst_locked", 1, 32'(LOCKED1), 32'd0);
      #1;
      RESET      = 1'b0;
      BIT_VALID0 = 1'b0;
   endtask

   initial begin
      do_reset();
      mon_en = 1'b1;

      for (int i = 0; i < 5; i++) apply_stimulus(0, 1'($urandom_range(0, 1)), 1'b1);
      send_word(0, 10'h0BC);
      send_word(0, 10'h0A5);
      send_word(0, 10'h03C);

      // 5A with a three-cycle BIT_VALID gap after its second bit
      apply_stimulus(0, 1'b0, 1'b1);
      apply_stimulus(0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) apply_stimulus(0, 1'($urandom_range(0, 1)), 1'b0);
      for (int i = 5; i >= 0; i--) apply_stimulus(0, (8'h5A >> i) & 1'b1, 1'b1);
      idle(3);

      for (int i = 0; i < 4; i++) apply_stimulus(0, 1'($urandom_range(0, 1)), 1'b1);
      do_reset();
      send_word(0, 10'h0BC);

      send_word(0, 10'h011);
      send_word(0, 10'h022);
      send_word(0, 10'h033);
      send_word(0, 10'h044);
      idle(2);
      send_word(0, 10'h0BC);

      send_word(0, 10'h011);
      send_word(0, 10'h022);
      send_word(0, 10'h033);
      send_word(0, 10'h0BC);
      send_word(0, 10'h055);
      send_word(0, 10'h066);
      send_word(0, 10'h077);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 15) == 0) send_word(0, 10'h0BC);
         else apply_stimulus(0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      end
      idle(4);

      send_word(1, 10'h17C);
      for (int i = 0; i < 3; i++) send_word(1, 10'($urandom_range(0, 1023)));
      idle(10);

      check("queue_empty", 0, 32'(q0.size()), 32'd0);
      check("queue_empty", 1, 32'(q1.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serial_parallel_sync.md
Name: serial_parallel_sync

Overview:
- Parametrised serial-to-parallel deserializer with comma-based word alignment, word-valid strobes and loss-of-sync detection.
- Hunts the bit stream for a configurable comma pattern, locks word boundaries to it, then emits one parallel word every WIDTH accepted bits.
- Sits between the serial line receiver and the byte/word-level datapath (descrambler, FIFO).

Parameters:
- WIDTH, 8, bits per parallel word (>=2).
- COMMA, 8'hBC, alignment pattern; WIDTH bits.
- MSB_FIRST, 1, 1: first received bit lands in DATA_OUT[WIDTH-1]; 0: first received bit lands in DATA_OUT[0].
- TIMEOUT_WORDS, 16, consecutive non-comma words in LOCKED before declaring loss of sync; 0 disables the timeout.

Ports:
- CLK  input  1  clock; all logic on posedge.
- RESET  input  1  synchronous, active-high reset.
- DATA_IN  input  1  serial data bit.
- BIT_VALID  input  1  DATA_IN is sampled only on edges where BIT_VALID=1; otherwise all state holds.
- DATA_OUT  output  WIDTH  last assembled word, registered; holds between strobes.
- DATA_VALID  output  1  one-cycle pulse, DATA_OUT updated this cycle.
- IS_COMMA  output  1  qualifies DATA_VALID; current DATA_OUT equals COMMA.
- LOCKED  output  1  level; high while word alignment is established.
- SYNC_LOSS  output  1  one-cycle pulse on LOCKED->SEARCH transition caused by timeout.

Behaviour:
- Reset: DATA_OUT=0, DATA_VALID=0, IS_COMMA=0, LOCKED=0, SYNC_LOSS=0. Shift register, bit counter and word counter are cleared. State=SEARCH.
- Reset has priority over every other event, including mid-word in LOCKED. The partial word is discarded.
- Assembled candidate word W_next:
  - MSB_FIRST=1: W_next = {sr[WIDTH-2:0], DATA_IN}.
  - MSB_FIRST=0: W_next = {DATA_IN, sr[WIDTH-1:1]}.
- The shift register loads W_next on every accepted bit.
- DATA_VALID, IS_COMMA and SYNC_LOSS default to 0 every cycle. They are only high the cycle after an edge that asserts them.
- BIT_VALID=0 edge: no shift, no counter change, pulses drop to 0, DATA_OUT/LOCKED hold.
- State SEARCH (accepted bit):
  - If W_next==COMMA: DATA_OUT<=COMMA, DATA_VALID<=1, IS_COMMA<=1, LOCKED<=1, bitcnt<=0, wordcnt<=0, state->LOCKED.
  - Else: shift only.
  - Latency: outputs visible one clock after the edge sampling the comma's last bit.
- State LOCKED (accepted bit):
  - bitcnt increments 0..WIDTH-1.
  - At bitcnt==WIDTH-1: DATA_OUT<=W_next, DATA_VALID<=1, IS_COMMA<=(W_next==COMMA), bitcnt<=0.
  - A word is emitted exactly every WIDTH accepted bits after the locking comma.
- Comma handling while LOCKED:
  - Only aligned words are compared against COMMA; misaligned comma patterns are ignored (no realignment while locked).
  - Aligned comma word: wordcnt<=0.
  - Non-comma word: wordcnt+1.
- Timeout (TIMEOUT_WORDS>0):
  - When a non-comma word brings wordcnt to TIMEOUT_WORDS, that word is still emitted with DATA_VALID=1.
  - In the same edge: SYNC_LOSS<=1, LOCKED<=0, state->SEARCH, bitcnt/wordcnt cleared.
  - The shift register keeps its contents, so a comma straddling the boundary can be found immediately.
- wordcnt width: clog2(TIMEOUT_WORDS+1); it saturates and never wraps.
- bitcnt width: clog2(WIDTH).
- Simultaneous comma and timeout on the same word: comma wins, no SYNC_LOSS.
- BIT_VALID gaps in the middle of a word do not affect alignment.

Decomposition:
- Shared package serial_pkg:
  - Default comma constants: K28_5 = 8'hBC.
  - State encoding localparams: ST_SEARCH, ST_LOCKED.
  - clog2 helper function.
- One natural sub-module, comma_detector: combinational, parametrised on WIDTH/COMMA, returns match for W_next. It is reused by future multi-lane aligners.
- The shift register and the FSM stay in the top module.

Test Plan:
- Reset mid-word: lock on 8'hBC, send 4 bits, assert RESET 1 cycle -> all outputs 0 and LOCKED=0. The next 8'hBC relocks with the DATA_VALID pulse exactly 1 clock after its last bit.
- Lock with random prefix: 5 random bits, then BC, then A5, 3C (MSB first) -> one DATA_VALID pulse per word: BC with IS_COMMA=1, then A5, 3C. Pulses are exactly 8 clocks apart. LOCKED rises with the first pulse.
- BIT_VALID gaps: send 8'h5A with BIT_VALID low for 3 cycles after bit 2 -> DATA_OUT=5A, emitted 11 clocks after its first bit, alignment unchanged.
- Timeout: TIMEOUT_WORDS=4, lock, send 4 non-comma words 11,22,33,44 -> all 4 emitted. SYNC_LOSS pulses in the same cycle as 44's DATA_VALID, and LOCKED falls together with it. The next BC relocks.
- Comma refresh: TIMEOUT_WORDS=4, pattern 11,22,33,BC,55,66,77 -> no SYNC_LOSS, LOCKED stays 1 throughout.
- LSB-first, WIDTH=10, COMMA=10'h17C: serial bits 0,0,1,1,1,1,1,0,1,0 -> DATA_OUT=17C, IS_COMMA=1, LOCKED=1.
